// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end. Issues one fetch at a time to the instruction
//   port of memory_controller (req/ack), buffers up to DEPTH fetched words in a
//   registered circular queue and presents the head {pc, instr} to if_id.
//   Branch redirects flush the queue and retarget the fetch PC; a redirect that
//   lands while a request is outstanding marks that request for squashing so
//   its late data is dropped.
//
// Optional feature: define FETCH_PERF_EN to add saturating 16-bit counters
//   perf_flush_cnt (redirects) and perf_stall_cnt (stalled cycles with a valid
//   head). Without the macro those ports do not exist.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   stall        in   decode stall, keep the queue head
//   b_taken      in   one-cycle branch redirect strobe
//   b_pc         in   redirect target
//   mem_req      out  fetch request, held until mem_ack
//   mem_addr     out  fetch address, stable while mem_req=1
//   mem_ack      in   read data valid
//   mem_rdata    in   fetched instruction word
//   if_id_valid  out  queue head valid
//   if_id_pc     out  head PC (holds last value when empty)
//   if_id_instr  out  head instruction (holds last value when empty)
//   fill_level   out  queue occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     b_taken,
    input  logic [XLEN-1:0]          b_pc,
    output logic                     mem_req,
    output logic [XLEN-1:0]          mem_addr,
    input  logic                     mem_ack,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic                     if_id_valid,
    output logic [XLEN-1:0]          if_id_pc,
    output logic [XLEN-1:0]          if_id_instr,
    output logic [$clog2(DEPTH):0]   fill_level
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]              perf_flush_cnt,
    output logic [15:0]              perf_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t            state_q, state_n;
    logic              squash_q, squash_n;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_n;
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [AW-1:0]     rd_ptr_inc;
    logic [CW-1:0]     count_q;
    logic              push, pop, credit;
    logic              head_from_push, head_from_q;

    logic [XLEN-1:0]   q_pc    [DEPTH];
    logic [XLEN-1:0]   q_instr [DEPTH];

    // Only one request is ever outstanding, so in IDLE the credit check
    // reduces to "queue not full".
    assign credit      = (count_q < DEPTH_C);
    assign mem_req     = (state_q == S_REQ);
    assign if_id_valid = (count_q != '0);
    assign fill_level  = count_q;

    // A redirect flushes the queue, so it also suppresses the pop.
    assign pop        = if_id_valid && !stall && !b_taken;
    assign rd_ptr_inc = rd_ptr_q + AW'(1);

    // Head register source: the incoming word when the queue is (or becomes)
    // empty at this edge, otherwise the next stored entry after a pop.
    assign head_from_push = push && ((count_q == '0) || ((count_q == CW'(1)) && pop));
    assign head_from_q    = pop && (count_q > CW'(1));

    always_comb begin
        state_n    = state_q;
        squash_n   = squash_q;
        fetch_pc_n = fetch_pc_q;
        push       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // After a redirect the queue is empty, so credit is implied.
                if (b_taken || credit) begin
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    squash_n = 1'b0;
                    if (b_taken || squash_q) begin
                        // Data belongs to a stale path: drop it and start the
                        // fetch at the redirect target right away.
                        state_n = S_REQ;
                    end else begin
                        state_n    = S_IDLE;
                        push       = 1'b1;
                        fetch_pc_n = mem_addr + XLEN'(PC_STEP);
                    end
                end else if (b_taken) begin
                    squash_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (b_taken) begin
            fetch_pc_n = b_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            squash_q    <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            mem_addr    <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else begin
            state_q    <= state_n;
            squash_q   <= squash_n;
            fetch_pc_q <= fetch_pc_n;

            // The address must not move while a request waits for its ack.
            if (!((state_q == S_REQ) && !mem_ack)) begin
                mem_addr <= fetch_pc_n;
            end

            if (b_taken) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_inc;
                end
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
                if (head_from_push) begin
                    if_id_pc    <= mem_addr;
                    if_id_instr <= mem_rdata;
                end else if (head_from_q) begin
                    if_id_pc    <= q_pc[rd_ptr_inc];
                    if_id_instr <= q_instr[rd_ptr_inc];
                end
            end
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_q]    <= mem_addr;
            q_instr[wr_ptr_q] <= mem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (b_taken) begin
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            end
            if (stall && if_id_valid) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
        end
    end
`endif

endmodule
